gcd_lcm_engine: RTL and testbench



---
 rtl/gcd_lcm_engine_if.sv | 24 ++
 rtl/gcd_lcm_engine.sv | 185 ++++++++++++++++++
 tb/tb_gcd_lcm_engine.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/gcd_lcm_engine_if.sv
// Valid/ready request and result channels of the GCD/LCM engine.
// The producer/consumer side uses master; the engine uses slave.
interface gcd_lcm_engine_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/gcd_lcm_engine.sv
// Handshaked GCD (binary Stein) / LCM engine, one operation in flight.
// Optional saturating cycle counter port enabled by GCD_CYCLE_COUNT_EN.
module gcd_lcm_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  gcd_lcm_engine_if.slave  bus,
  output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] cycles
`endif
);

  localparam int KW = $clog2(WIDTH) + 1;
  localparam int DW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    REDUCE,
    DIV,
    MUL,
    DONE
  } state_t;

  state_t state;
  state_t state_d;

  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic [WIDTH-1:0]   ka;
  logic [WIDTH-1:0]   kb;
  logic               md;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   g;
  logic [WIDTH-1:0]   dq;
  logic [WIDTH-1:0]   rem;
  logic [DW-1:0]      div_cnt;
  logic [2*WIDTH-1:0] result_q;

  logic               accept;
  logic               zero_op;
  logic               both_even;
  logic               equal;
  logic               div_last;
  logic [WIDTH-1:0]   gcd_val;
  logic [WIDTH:0]     rem_shift;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] product;

  assign accept    = bus.in_valid && (state == IDLE);
  assign zero_op   = (bus.a == '0) || (bus.b == '0);
  assign both_even = !x[0] && !y[0];
  assign equal     = (x == y);
  assign div_last  = (div_cnt == DW'(WIDTH - 1));
  assign gcd_val   = x << k;

  // Restoring division: dq shifts the dividend out and the quotient bits in.
  assign rem_shift = {rem, dq[WIDTH-1]};
  assign q_bit     = (rem_shift >= {1'b0, g});
  assign rem_next  = q_bit ? WIDTH'(rem_shift - {1'b0, g}) : rem_shift[WIDTH-1:0];
  assign product   = (2*WIDTH)'(dq) * (2*WIDTH)'(kb);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = zero_op ? DONE : SHIFT;
      SHIFT:   if (!both_even) state_d = REDUCE;
      REDUCE:  if (equal) state_d = md ? DIV : DONE;
      DIV:     if (div_last) state_d = MUL;
      MUL:     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    busy          = (state != IDLE);
    bus.result    = result_q;
  end

  // Working registers; result_q is only written on the way into DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x        <= '0;
      y        <= '0;
      ka       <= '0;
      kb       <= '0;
      md       <= 1'b0;
      k        <= '0;
      g        <= '0;
      dq       <= '0;
      rem      <= '0;
      div_cnt  <= '0;
      result_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            x  <= bus.a;
            y  <= bus.b;
            ka <= bus.a;
            kb <= bus.b;
            md <= bus.mode;
            k  <= '0;
            if (zero_op) begin
              result_q <= bus.mode ? '0 : {{WIDTH{1'b0}}, bus.a | bus.b};
            end
          end
        end
        SHIFT: begin
          if (both_even) begin
            x <= x >> 1;
            y <= y >> 1;
            k <= k + 1'b1;
          end
        end
        REDUCE: begin
          if (equal) begin
            g       <= gcd_val;
            dq      <= ka;
            rem     <= '0;
            div_cnt <= '0;
            if (!md) begin
              result_q <= {{WIDTH{1'b0}}, gcd_val};
            end
          end else if (!x[0]) begin
            x <= x >> 1;
          end else if (!y[0]) begin
            y <= y >> 1;
          end else if (x > y) begin
            x <= x - y;
          end else begin
            y <= y - x;
          end
        end
        DIV: begin
          rem     <= rem_next;
          dq      <= {dq[WIDTH-2:0], q_bit};
          div_cnt <= div_cnt + 1'b1;
        end
        MUL: begin
          result_q <= product;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts working cycles only, so it stays frozen through DONE and IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if ((state inside {SHIFT, REDUCE, DIV, MUL}) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cycles = cnt_q;
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_gcd_lcm_engine.sv
// Directed self-checking bench for gcd_lcm_engine at WIDTH=8.
// Checks the cycles port as well when GCD_CYCLE_COUNT_EN is defined.
module tb_gcd_lcm_engine;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
`ifdef GCD_CYCLE_COUNT_EN
  logic [7:0] cycles;
`endif

  int checks = 0;
  int errors = 0;
  int lat;

  gcd_lcm_engine_if #(.WIDTH(WIDTH)) bus ();

  gcd_lcm_engine #(
    .WIDTH(WIDTH),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .busy(busy)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Presents one request for a single edge; the engine must be idle.
  task automatic apply_stimulus(input logic m, input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    check_output("in_ready_before_accept", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a        = va;
    bus.b        = vb;
    bus.mode     = m;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int edges);
    edges = 0;
    while (!bus.out_valid && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check_output("out_valid_reached", bus.out_valid, 1);
  endtask

  task automatic finish_handshake(input string tag);
    @(posedge clk);
    #1;
    check_output({tag, "_out_valid_dropped"}, bus.out_valid, 0);
    check_output({tag, "_in_ready_back"}, bus.in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;
    reset_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_in_ready", bus.in_ready, 1);
    check_output("reset_out_valid", bus.out_valid, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_result", bus.result, 0);
`ifdef GCD_CYCLE_COUNT_EN
    check_output("reset_cycles", cycles, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // gcd(48,18) = 6, one result pulse, bounded latency
    apply_stimulus(1'b0, 8'd48, 8'd18);
    check_output("gcd48_18_busy", busy, 1);
    check_output("gcd48_18_in_ready_low", bus.in_ready, 0);
    wait_result(lat);
    check_output("gcd48_18_result", bus.result, 6);
    check_output("gcd48_18_latency_le_34", (lat <= 34), 1);
    finish_handshake("gcd48_18");
    @(posedge clk);
    #1;
    check_output("gcd48_18_single_pulse", bus.out_valid, 0);

    // lcm(255,254) = 64770
    apply_stimulus(1'b1, 8'd255, 8'd254);
    wait_result(lat);
    check_output("lcm255_254_result", bus.result, 16'hFD02);
`ifdef GCD_CYCLE_COUNT_EN
    check_output("lcm255_254_cycles_gt_width", (cycles > WIDTH), 1);
`endif
    finish_handshake("lcm255_254");

    // zero operands go straight to DONE
    apply_stimulus(1'b0, 8'd0, 8'd9);
    check_output("gcd0_9_done_next_cycle", bus.out_valid, 1);
    check_output("gcd0_9_result", bus.result, 9);
    finish_handshake("gcd0_9");
    apply_stimulus(1'b1, 8'd0, 8'd5);
    check_output("lcm0_5_done_next_cycle", bus.out_valid, 1);
    check_output("lcm0_5_result", bus.result, 0);
    finish_handshake("lcm0_5");
    apply_stimulus(1'b0, 8'd0, 8'd0);
    check_output("gcd0_0_done_next_cycle", bus.out_valid, 1);
    check_output("gcd0_0_result", bus.result, 0);
    finish_handshake("gcd0_0");

    // backpressure on lcm(4,6) = 12 with ignored requests during the stall
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, 8'd4, 8'd6);
    wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      check_output("stall_out_valid", bus.out_valid, 1);
      check_output("stall_in_ready_low", bus.in_ready, 0);
      check_output("stall_result", bus.result, 12);
      @(negedge clk);
      bus.in_valid = i[0];
      bus.a        = 8'd9;
      bus.b        = 8'd3;
      bus.mode     = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check_output("stall_result_after", bus.result, 12);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("stall_release_out_valid", bus.out_valid, 0);
    check_output("stall_release_in_ready", bus.in_ready, 1);
    check_output("stall_release_busy", busy, 0);
    apply_stimulus(1'b0, 8'd12, 8'd18);
    wait_result(lat);
    check_output("gcd12_18_after_stall", bus.result, 6);
    finish_handshake("gcd12_18");

    // power-of-two operands; operands scrambled after accept must not matter
    apply_stimulus(1'b0, 8'd64, 8'd96);
    bus.a = 8'd255;
    bus.b = 8'd1;
    wait_result(lat);
    check_output("gcd64_96_result", bus.result, 32);
    finish_handshake("gcd64_96");

    apply_stimulus(1'b1, 8'd12, 8'd18);
    wait_result(lat);
    check_output("lcm12_18_result", bus.result, 36);
    finish_handshake("lcm12_18");

    apply_stimulus(1'b0, 8'd7, 8'd7);
    wait_result(lat);
    check_output("gcd7_7_result", bus.result, 7);
    finish_handshake("gcd7_7");

    // asynchronous reset while reducing gcd(200,75)
    apply_stimulus(1'b0, 8'd200, 8'd75);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("midop_reset_out_valid", bus.out_valid, 0);
    check_output("midop_reset_in_ready", bus.in_ready, 1);
    check_output("midop_reset_busy", busy, 0);
    check_output("midop_reset_result", bus.result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(1'b0, 8'd21, 8'd14);
    wait_result(lat);
    check_output("gcd21_14_after_reset", bus.result, 7);
    finish_handshake("gcd21_14");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
